result_packer: RTL and testbench

Downstream stage of the systolic-array control unit. Consumes the serial byte stream of 16-bit signed results (c00 hi, c00 lo, c01 hi, c01 lo, c10 hi, c10 lo, c11 hi, c11 lo) and reassembles each 8-byte frame into four int8 values. Each value is requantized by a runtime arithmetic right shift with saturation. Packed frames are buffered in a small FIFO and delivered to the host over a valid/ready interface.

---
 rtl/tpu_pkg.sv | 16 +
 rtl/result_packer_if.sv | 20 ++
 rtl/result_fifo.sv | 45 ++++
 rtl/result_packer.sv | 117 +++++++++++
 tb/tb_result_packer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared constants for the systolic-array result path: frame geometry,
// accumulator/quantized widths, assembler state encodings and the FIFO entry layout.
package tpu_pkg;
   localparam int FRAME_BYTES = 8;
   localparam int N_ELEM      = 4;
   localparam int ACC_W       = 16;
   localparam int Q_W         = 8;

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_COLLECT = 1'b1;

   typedef struct packed {
      logic [N_ELEM*Q_W-1:0] data;
      logic [N_ELEM-1:0]     sat;
   } frame_t;
endpackage

// File: rtl/result_packer_if.sv
// Byte-stream input, host valid/ready output and status flags of result_packer.
interface result_packer_if;
   import tpu_pkg::*;
   logic                  clear;
   logic                  in_valid;
   logic                  in_first;
   logic [7:0]            in_data;
   logic [3:0]            shift;
   logic                  out_valid;
   logic                  out_ready;
   logic [N_ELEM*Q_W-1:0] out_data;
   logic [N_ELEM-1:0]     out_sat;
   logic                  overflow;
   logic                  frame_err;

   modport master (output clear, in_valid, in_first, in_data, shift, out_ready,
                   input  out_valid, out_data, out_sat, overflow, frame_err);
   modport slave  (input  clear, in_valid, in_first, in_data, shift, out_ready,
                   output out_valid, out_data, out_sat, overflow, frame_err);
endinterface

// File: rtl/result_fifo.sv
// Synchronous FIFO with simultaneous push/pop; a push into a full FIFO is taken
// only when a pop frees the slot in the same cycle.
module result_fifo #(
   parameter int W     = 36,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clear,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_wdata,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wptr, r_rptr;
   logic         w_do_push, w_do_pop;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty && !i_clear;
   assign w_do_push = i_push && (!o_full || w_do_pop) && !i_clear;
   assign o_rdata   = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_clear) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end
endmodule

// File: rtl/result_packer.sv
// Reassembles 8-byte frames of int16 results, requantizes to int8 with saturation
// and queues them for the host. Define RESULT_PACKER_RELU_EN to clamp negatives to 0.
module result_packer
   import tpu_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   result_packer_if.slave bus
);
   localparam int CW = $clog2(FRAME_BYTES);

   logic [0:0]                   r_state;
   logic [CW-1:0]                r_cnt;
   logic [FRAME_BYTES-1:0][7:0]  r_buf;
   logic [3:0]                   r_shift;
   logic                         r_done;
   logic                         r_overflow;
   logic                         r_frame_err;

   logic [N_ELEM*Q_W-1:0] w_q;
   logic [N_ELEM-1:0]     w_sat;
   frame_t                w_wr, w_rd;
   logic                  w_full, w_empty, w_push, w_pop;

   // in_first always restarts a frame; mid-frame it also flags the broken one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_buf       <= '0;
         r_shift     <= '0;
         r_done      <= 1'b0;
         r_frame_err <= 1'b0;
      end else if (bus.clear) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.in_valid) begin
            if (bus.in_first) begin
               if (r_state == S_COLLECT) r_frame_err <= 1'b1;
               r_buf[0] <= bus.in_data;
               r_shift  <= bus.shift;
               r_cnt    <= CW'(1);
               r_state  <= S_COLLECT;
            end else if (r_state == S_COLLECT) begin
               r_buf[r_cnt] <= bus.in_data;
               if (r_cnt == CW'(FRAME_BYTES-1)) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      logic signed [ACC_W-1:0] v;
      logic signed [ACC_W-1:0] r;
      w_q   = '0;
      w_sat = '0;
      v     = '0;
      r     = '0;
      for (int e = 0; e < N_ELEM; e++) begin
         v = {r_buf[2*e], r_buf[2*e+1]};
         r = v >>> r_shift;
`ifdef RESULT_PACKER_RELU_EN
         if (r < 0) r = '0;
`endif
         if (r > 16'sd127) begin
            w_q[e*Q_W +: Q_W] = 8'h7F;
            w_sat[e]          = 1'b1;
         end else if (r < -16'sd128) begin
            w_q[e*Q_W +: Q_W] = 8'h80;
            w_sat[e]          = 1'b1;
         end else begin
            w_q[e*Q_W +: Q_W] = r[Q_W-1:0];
         end
      end
   end

   assign w_wr.data = w_q;
   assign w_wr.sat  = w_sat;
   assign w_push    = r_done && !bus.clear;
   assign w_pop     = !w_empty && bus.out_ready && !bus.clear;

   result_fifo #(.W($bits(frame_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (bus.clear),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wr),
      .o_rdata (w_rd),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            r_overflow <= 1'b0;
      else if (bus.clear)                    r_overflow <= 1'b0;
      else if (w_push && w_full && !w_pop)   r_overflow <= 1'b1;
   end

   assign bus.out_valid = !w_empty;
   assign bus.out_data  = w_empty ? '0 : w_rd.data;
   assign bus.out_sat   = w_empty ? '0 : w_rd.sat;
   assign bus.overflow  = r_overflow;
   assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: requant, backpressure/overflow, full+pop,
// frame error with gaps, async reset and clear. Honours RESULT_PACKER_RELU_EN.
module tb_result_packer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   result_packer_if bus();

   result_packer #(.FIFO_DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [63:0] F_BASIC = 64'h0040_FFC0_0100_7FFF;
   localparam logic [63:0] F_A     = 64'h0001_0002_0003_0004;
   localparam logic [63:0] F_B     = 64'h0011_0012_0013_0014;
   localparam logic [63:0] F_C     = 64'h0021_0022_0023_0024;
   localparam logic [63:0] F_RST   = 64'h0005_FFFB_0080_FF7F;
   localparam logic [31:0] Q_A = 32'h04030201;
   localparam logic [31:0] Q_B = 32'h14131211;
   localparam logic [31:0] Q_C = 32'h24232221;
`ifdef RESULT_PACKER_RELU_EN
   localparam logic [31:0] Q_BASIC = 32'h7F100004;
   localparam logic [3:0]  S_BASIC = 4'b1000;
   localparam logic [31:0] Q_RST   = 32'h007F0005;
   localparam logic [3:0]  S_RST   = 4'b0100;
`else
   localparam logic [31:0] Q_BASIC = 32'h7F10FC04;
   localparam logic [3:0]  S_BASIC = 4'b1000;
   localparam logic [31:0] Q_RST   = 32'h807FFB05;
   localparam logic [3:0]  S_RST   = 4'b1100;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic f, input logic [7:0] d, input logic [3:0] sh);
      bus.in_valid = 1'b1;
      bus.in_first = f;
      bus.in_data  = d;
      bus.shift    = sh;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
   endtask

   // Gap cycles carry junk with in_valid low, including stray in_first.
   task automatic send_frame(input logic [63:0] fr, input logic [3:0] sh, input bit gaps);
      for (int i = 0; i < 8; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               bus.in_valid = 1'b0;
               bus.in_first = 1'($urandom_range(0, 1));
               bus.in_data  = 8'($urandom);
               @(negedge clk);
            end
         end
         send_byte(i == 0, fr[63-8*i -: 8], sh);
      end
   endtask

   task automatic chk_head(input string tag, input logic [31:0] q, input logic [3:0] s);
      chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_data"},  64'(bus.out_data),  64'(q));
      chk({tag, "_sat"},   64'(bus.out_sat),   64'(s));
   endtask

   initial begin
      bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_first = 1'b0;
      bus.in_data = '0; bus.shift = '0; bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_data",  64'(bus.out_data),  64'd0);
      chk("rst_sat",   64'(bus.out_sat),   64'd0);
      chk("rst_ovf",   64'(bus.overflow),  64'd0);
      chk("rst_ferr",  64'(bus.frame_err), 64'd0);
      rst_n = 1'b1;
      idle(1);

      // basic requant and 2-cycle latency
      bus.out_ready = 1'b1;
      send_frame(F_BASIC, 4'd4, 1'b0);
      chk("basic_lat1", 64'(bus.out_valid), 64'd0);
      idle(1);
      chk_head("basic", Q_BASIC, S_BASIC);
      idle(1);
      chk("basic_popped", 64'(bus.out_valid), 64'd0);

      // backpressure: third frame dropped
      bus.out_ready = 1'b0;
      send_frame(F_A, 4'd0, 1'b0);
      send_frame(F_B, 4'd0, 1'b0);
      send_frame(F_C, 4'd0, 1'b0);
      idle(1);
      chk("bp_ovf", 64'(bus.overflow), 64'd1);
      chk_head("bp_h1", Q_A, 4'b0000);
      bus.out_ready = 1'b1;
      idle(1);
      chk_head("bp_h2", Q_B, 4'b0000);
      idle(1);
      chk("bp_empty", 64'(bus.out_valid), 64'd0);
      chk("bp_ovf_sticky", 64'(bus.overflow), 64'd1);

      // frame error then gapped frame
      bus.out_ready = 1'b0;
      send_byte(1'b1, 8'h12, 4'd7);
      send_byte(1'b0, 8'h34, 4'd7);
      send_byte(1'b0, 8'h56, 4'd7);
      send_byte(1'b0, 8'h78, 4'd7);
      chk("ferr_clean", 64'(bus.frame_err), 64'd0);
      send_frame(F_BASIC, 4'd4, 1'b1);
      idle(2);
      chk("ferr_set", 64'(bus.frame_err), 64'd1);
      chk_head("ferr", Q_BASIC, S_BASIC);
      bus.out_ready = 1'b1;
      idle(1);
      chk("ferr_one_only", 64'(bus.out_valid), 64'd0);

      // clear with one frame queued and both flags set
      bus.out_ready = 1'b0;
      send_frame(F_A, 4'd0, 1'b0);
      idle(1);
      chk_head("clr_pre", Q_A, 4'b0000);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      chk("clr_valid", 64'(bus.out_valid), 64'd0);
      chk("clr_ovf",   64'(bus.overflow),  64'd0);
      chk("clr_ferr",  64'(bus.frame_err), 64'd0);
      chk("clr_data",  64'(bus.out_data),  64'd0);

      // full + simultaneous pop on push cycle
      send_frame(F_A, 4'd0, 1'b0);
      send_frame(F_B, 4'd0, 1'b0);
      send_frame(F_C, 4'd0, 1'b0);
      bus.out_ready = 1'b1;
      idle(1);
      chk("fp_ovf", 64'(bus.overflow), 64'd0);
      chk_head("fp_h2", Q_B, 4'b0000);
      idle(1);
      chk_head("fp_h3", Q_C, 4'b0000);
      idle(1);
      chk("fp_empty", 64'(bus.out_valid), 64'd0);

      // async reset mid-frame with one frame queued
      bus.out_ready = 1'b0;
      send_frame(F_A, 4'd0, 1'b0);
      send_byte(1'b1, 8'h11, 4'd0);
      send_byte(1'b0, 8'h22, 4'd0);
      send_byte(1'b1, 8'h33, 4'd0);
      send_byte(1'b0, 8'h44, 4'd0);
      chk("mr_pre_valid", 64'(bus.out_valid), 64'd1);
      chk("mr_pre_ferr",  64'(bus.frame_err), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_valid", 64'(bus.out_valid), 64'd0);
      chk("mr_data",  64'(bus.out_data),  64'd0);
      chk("mr_sat",   64'(bus.out_sat),   64'd0);
      chk("mr_ferr",  64'(bus.frame_err), 64'd0);
      chk("mr_ovf",   64'(bus.overflow),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      send_frame(F_RST, 4'd0, 1'b0);
      idle(1);
      chk_head("mr_post", Q_RST, S_RST);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
